// File: rtl/bit_scan_loop_if.sv
// Valid/ready bundle for the bit-scan stage:
// word in, popcount/MSB/zero result out.
interface bit_scan_loop_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic [CNT_W-1:0]  out_msb;
  logic              out_zero;

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_count,
    input  out_msb,
    input  out_zero
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_count,
    output out_msb,
    output out_zero
  );
endinterface

// File: rtl/bit_scan_loop.sv
// Iterative bit scanner: one bit per cycle, early exit at
// the last set bit; reports popcount, MSB index, zero flag.
module bit_scan_loop #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic            CLK,
  input  logic            RST,
  bit_scan_loop_if.slave  bus,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] sreg_q;
  logic [CNT_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  msb_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  msbo_q;
  logic              zero_q;
  logic              ovalid_q;

  logic [DATA_W-1:0] sreg_d;
  logic [CNT_W-1:0]  idx_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  msb_d;
  logic              last_d;

  // Values the scan registers take on this edge;
  // last_d marks the final set bit leaving the window.
  always_comb begin
    sreg_d = sreg_q >> 1;
    idx_d  = idx_q + CNT_W'(1);
    cnt_d  = cnt_q + CNT_W'(sreg_q[0]);
    msb_d  = sreg_q[0] ? idx_q : msb_q;
    last_d = (sreg_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      msb_q    <= '0;
      count_q  <= '0;
      msbo_q   <= '0;
      zero_q   <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sreg_q <= bus.in_data;
            idx_q  <= '0;
            cnt_q  <= '0;
            msb_q  <= '0;
            if (bus.in_data == '0) begin
              zero_q   <= 1'b1;
              count_q  <= '0;
              msbo_q   <= '0;
              ovalid_q <= 1'b1;
              state_q  <= HOLD;
            end else begin
              zero_q  <= 1'b0;
              state_q <= SCAN;
            end
          end
        end
        SCAN: begin
          sreg_q <= sreg_d;
          idx_q  <= idx_d;
          cnt_q  <= cnt_d;
          msb_q  <= msb_d;
          if (last_d) begin
            count_q  <= cnt_d;
            msbo_q   <= msb_d;
            ovalid_q <= 1'b1;
            state_q  <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            ovalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          ovalid_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) & ~RST;
  assign bus.out_valid = ovalid_q;
  assign bus.out_count = count_q;
  assign bus.out_msb   = msbo_q;
  assign bus.out_zero  = zero_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_bit_scan_loop.sv
// Directed bench for bit_scan_loop: vector table plus
// hand-written backpressure and reset-abort sequences.
module tb_bit_scan_loop;

  logic CLK;
  logic RST;
  logic busy;

  int checks;
  int errors;

  bit_scan_loop_if #(.DATA_W(32), .CNT_W(6)) bus ();

  bit_scan_loop #(.DATA_W(32), .CNT_W(6)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .bus  (bus),
    .busy (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    int          cnt;
    int          msb;
    bit          zero;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Called at a negedge; leaves just after the acceptance edge.
  task automatic send(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    chk("in_ready_before_accept", bus.in_ready, 1);
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Waits for out_valid and checks the result; ends at a negedge.
  task automatic wait_res(input string name, input int c,
                          input int m, input bit z,
                          input int lat);
    int n;
    bit busy_ok;
    n = 0;
    busy_ok = 1'b1;
    @(negedge CLK);
    while (!bus.out_valid && n < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge CLK);
      n++;
    end
    chk({name, "_valid"}, bus.out_valid, 1);
    chk({name, "_latency"}, n, lat);
    chk({name, "_busy_scan"}, busy_ok, 1);
    chk({name, "_count"}, bus.out_count, c);
    chk({name, "_msb"}, bus.out_msb, m);
    chk({name, "_zero"}, bus.out_zero, z);
    chk({name, "_busy_hold"}, busy, 1);
  endtask

  task automatic release_res(input string name);
    bus.out_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b0;
    @(negedge CLK);
    chk({name, "_valid_drop"}, bus.out_valid, 0);
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_idle_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{32'h0800_0007, 4, 27, 1'b0, 28};
    vecs[1] = '{32'h0000_0000, 0, 0, 1'b1, 0};
    vecs[2] = '{32'hFFFF_FFFF, 32, 31, 1'b0, 32};
    vecs[3] = '{32'h0000_0001, 1, 0, 1'b0, 1};
    vecs[4] = '{32'h8000_0000, 1, 31, 1'b0, 32};
    vecs[5] = '{32'h0000_00A5, 4, 7, 1'b0, 8};
    vecs[6] = '{32'h0001_0000, 1, 16, 1'b0, 17};
    vecs[7] = '{32'h0000_0000, 0, 0, 1'b1, 0};

    // Reset
    @(negedge CLK);
    chk("rst_in_ready_low", bus.in_ready, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_count", bus.out_count, 0);
    chk("rst_msb", bus.out_msb, 0);
    chk("rst_zero", bus.out_zero, 0);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].data);
      wait_res($sformatf("vec%0d", i), vecs[i].cnt,
               vecs[i].msb, vecs[i].zero, vecs[i].lat);
      release_res($sformatf("vec%0d", i));
    end

    // Backpressure in HOLD with a new word pending
    send(32'h0000_0003);
    wait_res("bp_first", 2, 1, 1'b0, 2);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_00F0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_count", bus.out_count, 2);
      chk("bp_hold_msb", bus.out_msb, 1);
      chk("bp_hold_in_ready", bus.in_ready, 0);
      @(negedge CLK);
    end
    bus.out_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b0;
    @(negedge CLK);
    chk("bp_bubble_valid", bus.out_valid, 0);
    chk("bp_bubble_busy", busy, 0);
    chk("bp_bubble_ready", bus.in_ready, 1);
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    wait_res("bp_second", 4, 7, 1'b0, 8);
    release_res("bp_second");

    // Reset abort mid-scan at idx=10
    send(32'h8000_0000);
    repeat (10) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("abort_busy", busy, 0);
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_count", bus.out_count, 0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (bus.out_valid) seen = 1'b1;
        @(negedge CLK);
      end
      chk("abort_no_result", seen, 0);
    end
    send(32'h0000_0003);
    wait_res("post_abort", 2, 1, 1'b0, 2);
    release_res("post_abort");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
